// File: rtl/tbird_seq_pkg.sv
// rtl/tbird_seq_pkg.sv - shared types and helpers for the tail-light sequencer
package tbird_pkg;

  // Controller modes; LEFT/RIGHT/HAZ are the "active" ones.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEFT  = 3'd1,
    RIGHT = 3'd2,
    HAZ   = 3'd3,
    REST  = 3'd4
  } tbird_state_e;

  // Counter width that never collapses to zero bits for a count of one.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/tbird_seq_if.sv
// rtl/tbird_seq_if.sv - driver requests in, lamp drive out
interface tbird_seq_if #(
  parameter int LAMPS = 3
);
  logic             left;
  logic             right;
  logic             hazard;
  logic             brake;
  logic [LAMPS-1:0] left_lamps;
  logic [LAMPS-1:0] right_lamps;
  logic             active;

  // Input synchroniser side: drives requests, observes lamps.
  modport master (
    output left, right, hazard, brake,
    input  left_lamps, right_lamps, active
  );

  // Sequencer side.
  modport slave (
    input  left, right, hazard, brake,
    output left_lamps, right_lamps, active
  );
endinterface

// File: rtl/tbird_seq_prescaler.sv
// rtl/tbird_seq_prescaler.sv - step-rate divider producing one tick per animation step
module tbird_prescaler
  import tbird_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = clog2_min1(STEP_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick is the last count of a step, so the next step starts from zero.
  assign tick = (cnt_q == LAST);

  // Next count: clear wins, otherwise wrap on tick or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tbird_seq.sv
// rtl/tbird_seq.sv - parametrised tail-light sequencer: turn, hazard, brake
module tbird_seq
  import tbird_pkg::*;
#(
  parameter int LAMPS       = 3,
  parameter int STEP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  tbird_seq_if.slave  bus
);

  localparam int            PW     = $clog2(LAMPS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(LAMPS);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  tbird_state_e     state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  logic [LAMPS-1:0] left_lamps_q, left_lamps_d;
  logic [LAMPS-1:0] right_lamps_q, right_lamps_d;
  logic             active_q, active_d;

  logic tick;
  logic clr;
  logic preempt;
  logic animating;

  // Lamp i lit iff i < p: the turn animation grows outward from lamp 0.
  function automatic logic [LAMPS-1:0] therm(input logic [PW-1:0] p);
    logic [LAMPS-1:0] m;
    m = '0;
    for (int i = 0; i < LAMPS; i++) begin
      m[i] = (PW'(i) < p);
    end
    return m;
  endfunction

  assign preempt   = bus.hazard || (bus.left && bus.right);
  assign animating = (state_q == LEFT) || (state_q == RIGHT);

  // Prescaler sits at zero in IDLE so the first phase gets a full step,
  // and restarts when hazard cuts into a turn.
  assign clr = (state_q == IDLE) || (animating && preempt);

  tbird_prescaler #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .tick    (tick)
  );

  // Next state and phase.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (preempt) begin
          state_d = HAZ;
          p_d     = P_ONE;
        end else if (bus.left) begin
          state_d = LEFT;
          p_d     = P_ONE;
        end else if (bus.right) begin
          state_d = RIGHT;
          p_d     = P_ONE;
        end
      end
      LEFT, RIGHT: begin
        if (preempt) begin
          state_d = HAZ;
          p_d     = P_ONE;
        end else if (tick) begin
          if (p_q < P_LAST) begin
            p_d = p_q + 1'b1;
          end else begin
            state_d = REST;
            p_d     = '0;
          end
        end
      end
      HAZ: begin
        if (tick) begin
          state_d = REST;
          p_d     = '0;
        end
      end
      REST: begin
        if (tick) begin
          state_d = IDLE;
          p_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        p_d     = '0;
      end
    endcase
  end

  // Lamp decode from the next state; brake lights any side not animating.
  always_comb begin
    left_lamps_d  = '0;
    right_lamps_d = '0;
    active_d      = 1'b0;
    unique case (state_d)
      LEFT: begin
        left_lamps_d  = therm(p_d);
        right_lamps_d = bus.brake ? '1 : '0;
        active_d      = 1'b1;
      end
      RIGHT: begin
        left_lamps_d  = bus.brake ? '1 : '0;
        right_lamps_d = therm(p_d);
        active_d      = 1'b1;
      end
      HAZ: begin
        left_lamps_d  = '1;
        right_lamps_d = '1;
        active_d      = 1'b1;
      end
      default: begin
        left_lamps_d  = bus.brake ? '1 : '0;
        right_lamps_d = bus.brake ? '1 : '0;
      end
    endcase
  end

  // FSM, phase counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      p_q           <= '0;
      left_lamps_q  <= '0;
      right_lamps_q <= '0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      left_lamps_q  <= left_lamps_d;
      right_lamps_q <= right_lamps_d;
      active_q      <= active_d;
    end
  end

  assign bus.left_lamps  = left_lamps_q;
  assign bus.right_lamps = right_lamps_q;
  assign bus.active      = active_q;

endmodule
